// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared constants for the instruction-memory fetch controller:
//                controller state encodings, NOP/EBREAK opcodes, reset PC.
//  Revision    : 1.0  initial release
// ============================================================================
package imem_pkg;

    // Controller states (2-bit encoding)
    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // RV32I canonical NOP (addi x0,x0,0) and EBREAK
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    // Default fetch PC after reset and after a completed program load
    localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl
//  Description : Owns the instruction RAM port. Arbitrates between a program
//                loader (valid/ready write handshake) and CPU instruction
//                fetch, and sequences the fetch PC (sequential, branch
//                redirect, stall, halt on EBREAK or fault).
//  Revision    : 1.0  initial release
// ============================================================================
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int          ADDR_W    = 7,
    parameter logic [31:0] RESET_PC  = RESET_PC_DFLT,
    parameter bit          BOOT_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              load_req,
    input  logic              cpu_stall,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       pc_out,
    output logic [31:0]       instr,
    output logic              instr_vld,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       fetch_cnt
);

    localparam logic [1:0] c_BOOT_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;

    logic [1:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr;
    logic        r_instr_vld;
    logic        r_fault;
    logic [31:0] r_fetch_cnt;

    logic w_in_load;
    logic w_eff_stall;
    logic w_ebreak;
    logic w_misalign;
    logic w_oob;
    logic w_fault_halt;
    logic w_halt;

    assign w_in_load = (r_state == ST_LOAD);

    // A taken branch overrides a stall, so only an un-redirected stall freezes fetch
    assign w_eff_stall = cpu_stall & ~br_taken;

    assign w_ebreak     = r_instr_vld & (r_instr == EBREAK_INSTR);
    assign w_misalign   = br_taken & (br_target[1:0] != 2'b00);
    // Any set bit above the RAM word index means the PC has run off the end;
    // the RAM address would alias, so this is treated as a fault, never a wrap
    assign w_oob        = ~w_eff_stall & (|r_fetch_pc[31:ADDR_W+2]);
    assign w_fault_halt = w_misalign | w_oob;
    assign w_halt       = w_ebreak | w_fault_halt;

    // RAM port: loader owns it in LOAD, fetch PC drives the address otherwise
    assign ld_ready  = w_in_load;
    assign mem_we    = w_in_load & ld_valid;
    assign mem_addr  = w_in_load ? ld_addr : r_fetch_pc[ADDR_W+1:2];
    assign mem_wdata = ld_data;

    assign halted    = (r_state == ST_HALT);
    assign pc_out    = r_pc_out;
    assign instr     = r_instr;
    assign instr_vld = r_instr_vld;
    assign fault     = r_fault;
    assign fetch_cnt = r_fetch_cnt;

    // Controller FSM with fetch PC, delivered instruction and fault flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_BOOT_STATE;
            r_fetch_pc  <= RESET_PC;
            r_pc_out    <= 32'h0;
            r_instr     <= NOP_INSTR;
            r_instr_vld <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_instr_vld <= 1'b0;
                    if (ld_valid && ld_last) begin
                        r_state    <= ST_RUN;
                        r_fetch_pc <= RESET_PC;
                    end
                end
                ST_RUN: begin
                    if (w_halt) begin
                        // Fault outcome wins when EBREAK coincides with a fault
                        r_state     <= ST_HALT;
                        r_instr_vld <= 1'b0;
                        if (w_fault_halt) begin
                            r_fault <= 1'b1;
                        end
                    end else if (br_taken) begin
                        // Word read this cycle is on the wrong path: drop it
                        r_fetch_pc  <= br_target;
                        r_instr_vld <= 1'b0;
                    end else if (!cpu_stall) begin
                        r_instr     <= mem_rdata;
                        r_pc_out    <= r_fetch_pc;
                        r_instr_vld <= 1'b1;
                        r_fetch_pc  <= r_fetch_pc + 32'd4;
                    end
                end
                ST_HALT: begin
                    r_instr_vld <= 1'b0;
                    if (load_req) begin
                        r_state <= ST_LOAD;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_HALT;
                    r_instr_vld <= 1'b0;
                end
            endcase
        end
    end

    // Count instructions actually consumed by decode (valid and not stalled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= 32'h0;
        end else if (r_instr_vld && !cpu_stall) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_ctrl
//  Description : Self-checking bench for imem_fetch_ctrl: table-driven
//                load/run/stall/branch vectors plus hand-written halt, reload,
//                run-off-end and mid-load reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [6:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        load_req;
    logic        cpu_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr;
    logic        instr_vld;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_cnt;

    logic [31:0] ram [128];

    int n_cmp;
    int n_bad;

    imem_fetch_ctrl #(
        .ADDR_W    (7),
        .RESET_PC  (32'h0),
        .BOOT_LOAD (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .load_req  (load_req),
        .cpu_stall (cpu_stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pc_out    (pc_out),
        .instr     (instr),
        .instr_vld (instr_vld),
        .halted    (halted),
        .fault     (fault),
        .fetch_cnt (fetch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External instruction RAM: combinational read, synchronous write
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    typedef struct {
        logic        vl;
        logic [6:0]  la;
        logic [31:0] ld;
        logic        last;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        e_we;
        logic [6:0]  e_ma;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid  = 1'b0;
        ld_addr   = 7'd0;
        ld_data   = 32'h0;
        ld_last   = 1'b0;
        load_req  = 1'b0;
        cpu_stall = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
    endtask

    task automatic load_word(input logic [6:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_last  = last;
        cyc();
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 128; i++) ram[i] = 32'hA000_0000 | 32'(i);
        idle_inputs();

        // ---------------- reset ----------------
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_vld", {31'h0, instr_vld}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_cnt", fetch_cnt, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_ld_ready", {31'h0, ld_ready}, 32'h1);
        cyc();
        rst_n = 1'b1;

        // ---------------- table: load 4 words, run, stall, branch ----------------
        //            vl la   ld             last st br tgt      we ma    rdy vld pc       ins            cnt
        tbl[0]  = '{1, 7'd0, 32'hC0DE_0000, 0, 0, 0, 32'h0,   1, 7'd0,  1, 0, 32'h0,  NOP,           32'd0};
        tbl[1]  = '{1, 7'd1, 32'hC0DE_0001, 0, 0, 0, 32'h0,   1, 7'd1,  1, 0, 32'h0,  NOP,           32'd0};
        tbl[2]  = '{1, 7'd2, 32'hC0DE_0002, 0, 1, 1, 32'h42,  1, 7'd2,  1, 0, 32'h0,  NOP,           32'd0};
        tbl[3]  = '{1, 7'd3, 32'hC0DE_0003, 1, 0, 0, 32'h0,   1, 7'd3,  1, 0, 32'h0,  NOP,           32'd0};
        tbl[4]  = '{1, 7'd5, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,   0, 7'd0,  0, 1, 32'h0,  32'hC0DE_0000, 32'd0};
        tbl[5]  = '{0, 7'd0, 32'h0,         0, 0, 0, 32'h0,   0, 7'd1,  0, 1, 32'h4,  32'hC0DE_0001, 32'd1};
        tbl[6]  = '{0, 7'd0, 32'h0,         0, 0, 0, 32'h0,   0, 7'd2,  0, 1, 32'h8,  32'hC0DE_0002, 32'd2};
        tbl[7]  = '{0, 7'd0, 32'h0,         0, 1, 0, 32'h0,   0, 7'd3,  0, 1, 32'h8,  32'hC0DE_0002, 32'd2};
        tbl[8]  = '{0, 7'd0, 32'h0,         0, 1, 0, 32'h0,   0, 7'd3,  0, 1, 32'h8,  32'hC0DE_0002, 32'd2};
        tbl[9]  = '{0, 7'd0, 32'h0,         0, 1, 0, 32'h0,   0, 7'd3,  0, 1, 32'h8,  32'hC0DE_0002, 32'd2};
        tbl[10] = '{0, 7'd0, 32'h0,         0, 0, 0, 32'h0,   0, 7'd3,  0, 1, 32'hC,  32'hC0DE_0003, 32'd3};
        tbl[11] = '{0, 7'd0, 32'h0,         0, 0, 1, 32'h40,  0, 7'd4,  0, 0, 32'hC,  32'hC0DE_0003, 32'd4};
        tbl[12] = '{0, 7'd0, 32'h0,         0, 0, 0, 32'h0,   0, 7'd16, 0, 1, 32'h40, 32'hA000_0010, 32'd4};
        tbl[13] = '{0, 7'd0, 32'h0,         0, 0, 0, 32'h0,   0, 7'd17, 0, 1, 32'h44, 32'hA000_0011, 32'd5};

        for (int i = 0; i < 14; i++) begin
            ld_valid  = tbl[i].vl;
            ld_addr   = tbl[i].la;
            ld_data   = tbl[i].ld;
            ld_last   = tbl[i].last;
            cpu_stall = tbl[i].stall;
            br_taken  = tbl[i].br;
            br_target = tbl[i].tgt;
            #1;
            chk($sformatf("v%0d_mem_we", i), {31'h0, mem_we}, {31'h0, tbl[i].e_we});
            chk($sformatf("v%0d_mem_addr", i), {25'h0, mem_addr}, {25'h0, tbl[i].e_ma});
            chk($sformatf("v%0d_ld_ready", i), {31'h0, ld_ready}, {31'h0, tbl[i].e_rdy});
            if (tbl[i].e_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].ld);
            cyc();
            chk($sformatf("v%0d_instr_vld", i), {31'h0, instr_vld}, {31'h0, tbl[i].e_vld});
            chk($sformatf("v%0d_pc_out", i), pc_out, tbl[i].e_pc);
            chk($sformatf("v%0d_instr", i), instr, tbl[i].e_ins);
            chk($sformatf("v%0d_fetch_cnt", i), fetch_cnt, tbl[i].e_cnt);
            chk($sformatf("v%0d_halted", i), {31'h0, halted}, 32'h0);
        end
        idle_inputs();
        chk("ram_word0", ram[0], 32'hC0DE_0000);
        chk("ram_word3", ram[3], 32'hC0DE_0003);
        chk("ram_word5_untouched", ram[5], 32'hA000_0005);

        // ---------------- misaligned branch -> fault halt ----------------
        br_taken  = 1'b1;
        br_target = 32'h42;
        cyc();
        idle_inputs();
        chk("mis_halted", {31'h0, halted}, 32'h1);
        chk("mis_fault", {31'h0, fault}, 32'h1);
        chk("mis_vld", {31'h0, instr_vld}, 32'h0);
        chk("mis_cnt", fetch_cnt, 32'd6);
        ld_valid = 1'b1;
        #1;
        chk("halt_ld_ready", {31'h0, ld_ready}, 32'h0);
        chk("halt_mem_we", {31'h0, mem_we}, 32'h0);
        cyc();
        chk("halt_hold", {31'h0, halted}, 32'h1);
        chk("halt_pc_frozen", pc_out, 32'h44);
        idle_inputs();
        load_req = 1'b1;
        cyc();
        idle_inputs();
        chk("reload_halted", {31'h0, halted}, 32'h0);
        chk("reload_fault_clr", {31'h0, fault}, 32'h0);
        chk("reload_ld_ready", {31'h0, ld_ready}, 32'h1);

        // ---------------- EBREAK at word 2 -> clean halt ----------------
        load_word(7'd0, 32'hB000_0000, 1'b0);
        load_word(7'd1, 32'hB000_0001, 1'b0);
        load_word(7'd2, EBREAK, 1'b0);
        load_word(7'd3, 32'hB000_0003, 1'b1);
        cyc();
        cyc();
        cyc();
        chk("ebk_pc", pc_out, 32'h8);
        chk("ebk_instr", instr, EBREAK);
        chk("ebk_not_halted_yet", {31'h0, halted}, 32'h0);
        cyc();
        chk("ebk_halted", {31'h0, halted}, 32'h1);
        chk("ebk_fault", {31'h0, fault}, 32'h0);
        chk("ebk_vld", {31'h0, instr_vld}, 32'h0);
        chk("ebk_pc_frozen", pc_out, 32'h8);
        load_req = 1'b1;
        cyc();
        idle_inputs();
        chk("ebk_reload_rdy", {31'h0, ld_ready}, 32'h1);

        // ---------------- sequential fetch past last word -> fault ----------------
        load_word(7'd0, 32'hD000_0000, 1'b0);
        load_word(7'd1, 32'hD000_0001, 1'b0);
        load_word(7'd2, 32'hD000_0002, 1'b1);
        for (int k = 0; k < 128; k++) cyc();
        chk("end_pc_last", pc_out, 32'h1FC);
        chk("end_instr_last", instr, 32'hA000_007F);
        chk("end_not_halted", {31'h0, halted}, 32'h0);
        cyc();
        chk("end_halted", {31'h0, halted}, 32'h1);
        chk("end_fault", {31'h0, fault}, 32'h1);
        chk("end_pc_frozen", pc_out, 32'h1FC);
        chk("end_cnt", fetch_cnt, 32'd137);

        // ---------------- asynchronous reset in the middle of a load ----------------
        load_req = 1'b1;
        cyc();
        idle_inputs();
        load_word(7'd9, 32'hE000_0009, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc_out, 32'h0);
        chk("arst_instr", instr, NOP);
        chk("arst_vld", {31'h0, instr_vld}, 32'h0);
        chk("arst_fault", {31'h0, fault}, 32'h0);
        chk("arst_cnt", fetch_cnt, 32'h0);
        chk("arst_halted", {31'h0, halted}, 32'h0);
        chk("arst_ld_ready", {31'h0, ld_ready}, 32'h1);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("arst_load_state", {31'h0, ld_ready}, 32'h1);
        chk("arst_ram_kept", ram[9], 32'hE000_0009);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
